can_tx_msg_queue: RTL and testbench
===================================

# can_tx_msg_queue

Parametrised CAN transmit message queue; the multi-slot successor to the single-frame transmit buffer. It accepts CAN frames byte-serially from the host: two header bytes carrying ID, RTR and DLC, then the data bytes. Completed frames are stored in a DEPTH-entry FIFO, and the oldest frame is presented in parallel to the frame generator, which pops it with a one-cycle initiate strobe.

## Interface
- DATA_W, default 8: width of one buffer byte / data_in.
- MAX_DATA, default 8: maximum data bytes per frame; also the DLC saturation point.
- DEPTH, default 4: number of complete frames stored. Must be a power of two, ≥2.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state.
- data_in  input  DATA_W  frame byte being loaded.
- tx_buff_ld  input  1  load strobe; one byte is taken per cycle while high.
- ld_abort  input  1  discards the partially loaded frame; has priority over tx_buff_ld in the same cycle.
- frame_gen_intl  input  1  frame generator has latched the head frame; pop it.
- tx_buff_busy  output  1  queue full; loads are refused.
- frame_valid  output  1  head frame present on the frame outputs.
- frame_out  output  (2+MAX_DATA)*DATA_W  head frame. Byte k occupies bits [k*DATA_W +: DATA_W]. Byte 0 is header 1, byte 1 is header 2.
- rtr  output  1  RTR bit of the head frame.
- dlc  output  4  raw DLC of the head frame.
- msg_count  output  $clog2(DEPTH)+1  number of stored frames.
- load_err  output  1  one-cycle pulse when a load strobe is refused (queue full).

## Operation
- Header byte 0 is ID[10:3]. Header byte 1 is {ID[2:0], RTR, DLC[3:0]}, with RTR at bit 4 and DLC at bits 3:0.
- Frame length in bytes is L = 2 + (RTR ? 0 : min(DLC, MAX_DATA)). DLC values 9..15 load MAX_DATA data bytes, and dlc outputs the raw value.
- Byte counter bc (0..L-1) addresses the staging register:
  - Each accepted strobe writes data_in to byte bc and increments bc.
  - L is decoded from the byte accepted at bc=1.
  - The strobe that writes byte L-1 commits the frame: the staging contents go into the FIFO at the write pointer, the write pointer increments, and bc returns to 0.
- Data bytes that are not loaded (index ≥ L) are stored as zero. The staging register is zero-filled at each commit and abort.
- A partially loaded frame is never visible on the outputs and does not count in msg_count.
- ld_abort forces bc to 0. It has no effect on stored frames.
- Queue states are EMPTY (count 0), PARTIAL, and FULL (count = DEPTH). Pointers wrap modulo DEPTH.
- Pop: when frame_gen_intl=1 and frame_valid=1, the read pointer increments. frame_gen_intl while empty is ignored.
- Commit and pop in the same cycle leave count unchanged and both pointers advance.
- tx_buff_busy = (count == DEPTH). A load strobe while busy is refused: nothing is written, bc holds, and load_err pulses. A frame cannot be mid-load when FULL is reached, because FULL is entered only by a commit.
- Outputs are read combinationally from the FIFO entry at the read pointer. When the queue is empty, frame_out, rtr and dlc are 0.

## Timing
- Reset values: tx_buff_busy=0, frame_valid=0, frame_out=0, rtr=0, dlc=0, msg_count=0, load_err=0. Reset also sets bc=0 and both pointers to 0.
- Reset asserted mid-load or mid-pop discards everything immediately, with no partial commit.
- Load throughput is one byte per cycle with no gaps required. Idle cycles between bytes are allowed and hold bc.
- Commit latency: frame_valid, msg_count and tx_buff_busy update in the cycle after the clock edge that accepted the last byte.
- Pop latency: the next frame appears, or frame_valid drops, in the cycle after the popping edge.
- Back-to-back frames can load on consecutive cycles. The byte following a commit is header byte 0 of the next frame.
- load_err is registered: it is high for exactly the cycle after a refused strobe.

## Test plan
- Data frame, 3 bytes: load 0xA5, 0x43, 0x11, 0x22, 0x33 (ID=0x52A, RTR=0, DLC=3) → frame_valid=1 one cycle after the 5th byte; bytes 0-4 = A5,43,11,22,33; bytes 5-9 = 0; dlc=3; rtr=0; msg_count=1.
- Remote frame: load 0xFF, 0xF8 (ID=0x7FF, RTR=1, DLC=8) → commits after 2 bytes; dlc=8; rtr=1; the next byte starts a new frame.
- DLC saturation: header 0x01, 0x0F, then 8 data bytes 0x10..0x17 → commits after 10 bytes; dlc=15; bytes 2-9 = 10..17.
- Fill and overflow: with DEPTH=4, load 4 frames → tx_buff_busy=1 and msg_count=4. A 5th-frame strobe then gives load_err=1 for one cycle and queue contents are unchanged. Pulsing frame_gen_intl clears busy, and the frames pop in FIFO order.
- Simultaneous commit and pop at count=2 → count stays 2; the head advances to the 2nd frame. Repeat across pointer wrap (≥6 frames through a 4-deep queue) with order preserved.
- Abort and reset: after 3 bytes of a frame, ld_abort → the next byte is treated as header 0 and no frame is stored. Asserting reset=0 with 2 frames queued and a partial load → all outputs go to 0 immediately.

Source files
------------

// File: rtl/can_tx_msg_queue.sv
// CAN transmit message queue: byte-serial frame loader feeding a DEPTH-entry
// frame FIFO whose head is presented in parallel to the frame generator.
module can_tx_msg_queue #(
    parameter int DATA_W   = 8,
    parameter int MAX_DATA = 8,
    parameter int DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_W-1:0]                data_in,
    input  logic                             tx_buff_ld,
    input  logic                             ld_abort,
    input  logic                             frame_gen_intl,
    output logic                             tx_buff_busy,
    output logic                             frame_valid,
    output logic [(2+MAX_DATA)*DATA_W-1:0]   frame_out,
    output logic                             rtr,
    output logic [3:0]                       dlc,
    output logic [$clog2(DEPTH):0]           msg_count,
    output logic                             load_err
);

    localparam int FRAME_W = (2 + MAX_DATA) * DATA_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BC_W    = $clog2(MAX_DATA + 2);

    typedef enum logic [1:0] {
        Q_EMPTY,
        Q_PARTIAL,
        Q_FULL
    } q_state_t;

    q_state_t               r_qState;
    q_state_t               w_qNext;

    logic [FRAME_W-1:0]     r_mem [DEPTH];
    logic [FRAME_W-1:0]     r_stage;
    logic [BC_W-1:0]        r_bc;
    logic [BC_W-1:0]        r_last;
    logic [PTR_W-1:0]       r_wrPtr;
    logic [PTR_W-1:0]       r_rdPtr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_loadErr;

    logic [FRAME_W-1:0]     w_frame;
    logic [BC_W-1:0]        w_decLast;
    logic [BC_W-1:0]        w_lastIdx;
    logic [CNT_W-1:0]       w_countNext;
    logic                   w_accept;
    logic                   w_refuse;
    logic                   w_commit;
    logic                   w_pop;

    assign w_accept = tx_buff_ld && !ld_abort && !tx_buff_busy;
    assign w_refuse = tx_buff_ld && !ld_abort && tx_buff_busy;
    assign w_pop    = frame_gen_intl && frame_valid;

    // Index of the last byte, decoded from header byte 1 (RTR at bit 4, DLC at 3:0).
    always_comb begin
        w_decLast = BC_W'(1);
        if (data_in[4]) begin
            w_decLast = BC_W'(1);
        end else if (int'(data_in[3:0]) > MAX_DATA) begin
            w_decLast = BC_W'(MAX_DATA + 1);
        end else begin
            w_decLast = BC_W'(data_in[3:0]) + BC_W'(1);
        end
    end

    assign w_lastIdx = (r_bc == BC_W'(1)) ? w_decLast : r_last;
    assign w_commit  = w_accept && (r_bc != '0) && (r_bc == w_lastIdx);

    // Staging contents with the byte being accepted this cycle merged in.
    always_comb begin
        w_frame = r_stage;
        w_frame[int'(r_bc)*DATA_W +: DATA_W] = data_in;
    end

    always_comb begin
        w_countNext = r_count;
        case ({w_commit, w_pop})
            2'b10:   w_countNext = r_count + CNT_W'(1);
            2'b01:   w_countNext = r_count - CNT_W'(1);
            default: w_countNext = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage   <= '0;
            r_bc      <= '0;
            r_last    <= '0;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_loadErr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_loadErr <= w_refuse;
            r_count   <= w_countNext;
            if (w_commit) begin
                r_mem[r_wrPtr] <= w_frame;
                r_wrPtr        <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            // Staging is zero-filled on commit/abort so unloaded data bytes read as zero.
            if (ld_abort || w_commit) begin
                r_bc    <= '0;
                r_stage <= '0;
            end else if (w_accept) begin
                r_bc    <= r_bc + BC_W'(1);
                r_stage <= w_frame;
                if (r_bc == BC_W'(1)) begin
                    r_last <= w_decLast;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_qState <= Q_EMPTY;
        end else begin
            r_qState <= w_qNext;
        end
    end

    always_comb begin
        w_qNext      = Q_PARTIAL;
        tx_buff_busy = 1'b0;
        frame_valid  = 1'b0;
        if (w_countNext == '0) begin
            w_qNext = Q_EMPTY;
        end else if (w_countNext == CNT_W'(DEPTH)) begin
            w_qNext = Q_FULL;
        end
        if (r_qState == Q_FULL) begin
            tx_buff_busy = 1'b1;
        end
        if (r_qState != Q_EMPTY) begin
            frame_valid = 1'b1;
        end
    end

    assign frame_out = frame_valid ? r_mem[r_rdPtr] : '0;
    assign rtr       = frame_out[DATA_W + 4];
    assign dlc       = frame_out[DATA_W +: 4];
    assign msg_count = r_count;
    assign load_err  = r_loadErr;

endmodule

// File: tb/tb_can_tx_msg_queue.sv
// Self-checking bench for can_tx_msg_queue: a vector table for load/fill/pop,
// then hand sequences for commit+pop across wrap, abort and async reset.
module tb_can_tx_msg_queue;

    localparam int FRAME_W = 80;

    typedef struct {
        logic               ld;
        logic               abort;
        logic               intl;
        logic [7:0]         data;
        logic               expValid;
        logic               expBusy;
        logic               expErr;
        logic [2:0]         expCount;
        logic               expRtr;
        logic [3:0]         expDlc;
        logic [FRAME_W-1:0] expFrame;
    } vec_t;

    logic               clk;
    logic               resetN;
    logic [7:0]         dataIn;
    logic               txBuffLd;
    logic               ldAbort;
    logic               frameGenIntl;
    logic               txBuffBusy;
    logic               frameValid;
    logic [FRAME_W-1:0] frameOut;
    logic               rtrOut;
    logic [3:0]         dlcOut;
    logic [2:0]         msgCount;
    logic               loadErr;

    int numChecks = 0;
    int numFails  = 0;
    vec_t vecs[$];

    can_tx_msg_queue #(.DATA_W(8), .MAX_DATA(8), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (resetN),
        .data_in        (dataIn),
        .tx_buff_ld     (txBuffLd),
        .ld_abort       (ldAbort),
        .frame_gen_intl (frameGenIntl),
        .tx_buff_busy   (txBuffBusy),
        .frame_valid    (frameValid),
        .frame_out      (frameOut),
        .rtr            (rtrOut),
        .dlc            (dlcOut),
        .msg_count      (msgCount),
        .load_err       (loadErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [FRAME_W-1:0] act,
                               input logic [FRAME_W-1:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic abort, input logic intl,
                                 input logic [7:0] data);
        @(negedge clk);
        txBuffLd     = ld;
        ldAbort      = abort;
        frameGenIntl = intl;
        dataIn       = data;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic ld, input logic abort, input logic intl,
                          input logic [7:0] data, input logic v, input logic b,
                          input logic e, input logic [2:0] c, input logic r,
                          input logic [3:0] d, input logic [FRAME_W-1:0] f);
        vec_t t;
        t.ld = ld; t.abort = abort; t.intl = intl; t.data = data;
        t.expValid = v; t.expBusy = b; t.expErr = e; t.expCount = c;
        t.expRtr = r; t.expDlc = d; t.expFrame = f;
        vecs.push_back(t);
    endtask

    task automatic checkAll(input string tag, input logic v, input logic b, input logic e,
                            input logic [2:0] c, input logic r, input logic [3:0] d,
                            input logic [FRAME_W-1:0] f);
        checkOutput({tag, " valid"}, FRAME_W'(frameValid), FRAME_W'(v));
        checkOutput({tag, " busy"},  FRAME_W'(txBuffBusy), FRAME_W'(b));
        checkOutput({tag, " err"},   FRAME_W'(loadErr),    FRAME_W'(e));
        checkOutput({tag, " count"}, FRAME_W'(msgCount),   FRAME_W'(c));
        checkOutput({tag, " rtr"},   FRAME_W'(rtrOut),     FRAME_W'(r));
        checkOutput({tag, " dlc"},   FRAME_W'(dlcOut),     FRAME_W'(d));
        checkOutput({tag, " frame"}, frameOut, f);
    endtask

    localparam logic [FRAME_W-1:0] FA = 80'h000000000033221143A5;
    localparam logic [FRAME_W-1:0] FR = 80'h0000000000000000F8FF;
    localparam logic [FRAME_W-1:0] FS = 80'h17161514131211100F01;
    localparam logic [FRAME_W-1:0] FQ = 80'h00000000000000003412;
    localparam logic [FRAME_W-1:0] FZ = '0;

    initial begin
        logic [7:0] hb;
        resetN = 1'b0; txBuffLd = 1'b0; ldAbort = 1'b0; frameGenIntl = 1'b0; dataIn = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 0, 0, 0, 3'd0, 0, 4'd0, FZ);
        @(negedge clk);
        resetN = 1'b1;

        addVec(0,0,0,8'h00, 0,0,0,3'd0,0,4'd0,FZ);
        addVec(1,0,0,8'hA5, 0,0,0,3'd0,0,4'd0,FZ);
        addVec(1,0,0,8'h43, 0,0,0,3'd0,0,4'd0,FZ);
        addVec(1,0,0,8'h11, 0,0,0,3'd0,0,4'd0,FZ);
        addVec(1,0,0,8'h22, 0,0,0,3'd0,0,4'd0,FZ);
        addVec(1,0,0,8'h33, 1,0,0,3'd1,0,4'd3,FA);
        addVec(0,0,0,8'h00, 1,0,0,3'd1,0,4'd3,FA);
        addVec(1,0,0,8'hFF, 1,0,0,3'd1,0,4'd3,FA);
        addVec(1,0,0,8'hF8, 1,0,0,3'd2,0,4'd3,FA);
        addVec(1,0,0,8'h01, 1,0,0,3'd2,0,4'd3,FA);
        addVec(1,0,0,8'h0F, 1,0,0,3'd2,0,4'd3,FA);
        for (int j = 0; j < 8; j++) begin
            addVec(1,0,0,8'(8'h10 + j), 1,0,0,(j == 7) ? 3'd3 : 3'd2,0,4'd3,FA);
        end
        addVec(1,0,0,8'h12, 1,0,0,3'd3,0,4'd3,FA);
        addVec(1,0,0,8'h34, 1,1,0,3'd4,0,4'd3,FA);
        addVec(1,0,0,8'h55, 1,1,1,3'd4,0,4'd3,FA);
        addVec(0,0,0,8'h00, 1,1,0,3'd4,0,4'd3,FA);
        addVec(0,0,1,8'h00, 1,0,0,3'd3,1,4'd8,FR);
        addVec(0,0,1,8'h00, 1,0,0,3'd2,0,4'hF,FS);
        addVec(0,0,1,8'h00, 1,0,0,3'd1,1,4'd4,FQ);
        addVec(0,0,1,8'h00, 0,0,0,3'd0,0,4'd0,FZ);
        addVec(0,0,1,8'h00, 0,0,0,3'd0,0,4'd0,FZ);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].ld, vecs[k].abort, vecs[k].intl, vecs[k].data);
            checkAll($sformatf("v%0d", k), vecs[k].expValid, vecs[k].expBusy, vecs[k].expErr,
                     vecs[k].expCount, vecs[k].expRtr, vecs[k].expDlc, vecs[k].expFrame);
        end

        // Two remote frames, then six commits each coinciding with a pop (wraps pointers).
        for (int i = 1; i <= 2; i++) begin
            applyStimulus(1, 0, 0, 8'(i));
            applyStimulus(1, 0, 0, 8'h10);
        end
        checkOutput("wrap start count", FRAME_W'(msgCount), FRAME_W'(2));
        for (int i = 3; i <= 8; i++) begin
            applyStimulus(1, 0, 0, 8'(i));
            checkOutput($sformatf("wrap%0d mid count", i), FRAME_W'(msgCount), FRAME_W'(2));
            applyStimulus(1, 0, 1, 8'h10);
            hb = 8'(i - 1);
            checkOutput($sformatf("wrap%0d count", i), FRAME_W'(msgCount), FRAME_W'(2));
            checkOutput($sformatf("wrap%0d head", i), frameOut, {64'h0, 8'h10, hb});
        end
        applyStimulus(0, 0, 1, 8'h00);
        checkAll("wrap pop1", 1, 0, 0, 3'd1, 1, 4'd0, {64'h0, 8'h10, 8'h08});
        applyStimulus(0, 0, 1, 8'h00);
        checkAll("wrap pop2", 0, 0, 0, 3'd0, 0, 4'd0, FZ);

        // Abort after three bytes, with a concurrent strobe that must be ignored.
        applyStimulus(1, 0, 0, 8'h20);
        applyStimulus(1, 0, 0, 8'h05);
        applyStimulus(1, 0, 0, 8'hAA);
        applyStimulus(1, 1, 0, 8'h99);
        checkOutput("abort count", FRAME_W'(msgCount), FRAME_W'(0));
        applyStimulus(1, 0, 0, 8'h30);
        applyStimulus(1, 0, 0, 8'h10);
        checkAll("after abort", 1, 0, 0, 3'd1, 1, 4'd0, {64'h0, 8'h10, 8'h30});

        // Second frame queued, then a partial load interrupted by reset.
        applyStimulus(1, 0, 0, 8'h31);
        applyStimulus(1, 0, 0, 8'h10);
        applyStimulus(1, 0, 0, 8'h40);
        applyStimulus(1, 0, 0, 8'h02);
        checkOutput("pre-reset count", FRAME_W'(msgCount), FRAME_W'(2));
        @(negedge clk);
        txBuffLd = 1'b0;
        resetN   = 1'b0;
        #1;
        checkAll("async reset", 0, 0, 0, 3'd0, 0, 4'd0, FZ);
        @(negedge clk);
        resetN = 1'b1;
        applyStimulus(1, 0, 0, 8'h50);
        checkOutput("post-reset partial", FRAME_W'(frameValid), FRAME_W'(0));
        applyStimulus(1, 0, 0, 8'h10);
        checkAll("post-reset frame", 1, 0, 0, 3'd1, 1, 4'd0, {64'h0, 8'h10, 8'h50});
        applyStimulus(0, 0, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
